// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS decode constants: ALU opcodes, funct codes, ALUOp codes
package mips_pkg;

  // 3-bit operation codes understood by the 32-bit ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Main-decoder ALUOp values
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLTI  = 2'b11;

endpackage

// File: rtl/alu_control.sv
// rtl/alu_control.sv - combinational ALUOp/funct to ALU operation decoder
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_operation
);

  // ALUOp selects a fixed operation except for R-type, where funct decides;
  // unknown funct values fall back to add so the ALU never sees an undefined code
  always_comb begin
    alu_operation = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:  alu_operation = ALU_ADD;
      ALUOP_SUB:  alu_operation = ALU_SUB;
      ALUOP_SLTI: alu_operation = ALU_SLT;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_operation = ALU_ADD;
          FUNCT_SUB: alu_operation = ALU_SUB;
          FUNCT_AND: alu_operation = ALU_AND;
          FUNCT_OR:  alu_operation = ALU_OR;
          FUNCT_SLT: alu_operation = ALU_SLT;
          default:   alu_operation = ALU_ADD;
        endcase
      end
      default: alu_operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, ALU decode and load-use detection
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic [XLEN-1:0]  id_rt_data,
  input  logic [15:0]      id_imm,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic [1:0]       id_alu_op,
  input  logic [5:0]       id_funct,
  input  logic             mem_reg_write,
  input  logic [RADDR-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_reg_write,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_result,
  output logic             hazard_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_operation,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [RADDR-1:0] ex_write_reg,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg
);

  logic [RADDR-1:0] ex_rs;
  logic [RADDR-1:0] ex_rt;
  logic [XLEN-1:0]  ex_rs_data;
  logic [XLEN-1:0]  ex_rt_data;
  logic [15:0]      ex_imm;
  logic             ex_alu_src;

  logic [2:0]       id_alu_operation;
  logic [XLEN-1:0]  cap_rs_data;
  logic [XLEN-1:0]  cap_rt_data;
  logic [XLEN-1:0]  fwd_rs;
  logic [XLEN-1:0]  fwd_rt;
  logic [XLEN-1:0]  imm_ext;

  alu_control u_alu_control (
    .alu_op        (id_alu_op),
    .funct         (id_funct),
    .alu_operation (id_alu_operation)
  );

  // A load in EX cannot forward its data yet, so a dependent ID instruction must wait one cycle
  assign hazard_stall = ex_valid && ex_mem_read && (ex_write_reg != '0) && id_valid &&
                        ((id_rs == ex_write_reg) || (id_rt == ex_write_reg));

  // The register file does not write-through, so a same-cycle WB write is bypassed at capture
  always_comb begin
    cap_rs_data = id_rs_data;
    cap_rt_data = id_rt_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs)) cap_rs_data = wb_result;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt)) cap_rt_data = wb_result;
  end

  // EX-time operand forwarding; the younger MEM result wins over WB, r0 is never forwarded
  always_comb begin
    fwd_rs = ex_rs_data;
    fwd_rt = ex_rt_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs))     fwd_rs = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs))   fwd_rs = wb_result;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rt))     fwd_rt = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt))   fwd_rt = wb_result;
  end

  assign imm_ext       = {{(XLEN-16){ex_imm[15]}}, ex_imm};
  assign alu_a         = fwd_rs;
  assign alu_b         = ex_alu_src ? imm_ext : fwd_rt;
  assign ex_store_data = fwd_rt;

  // Stage register: reset, then flush, then hold on stall, then bubble on load-use, else capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_write_reg  <= '0;
      alu_operation <= ALU_AND;
    end else if (flush || (!stall && hazard_stall)) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_alu_src    <= id_alu_src;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rs_data    <= cap_rs_data;
      ex_rt_data    <= cap_rt_data;
      ex_imm        <= id_imm;
      ex_write_reg  <= id_reg_dst ? id_rd : id_rt;
      alu_operation <= id_alu_operation;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        hazard_stall, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_operation;
  logic [4:0]  ex_write_reg;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_op(id_alu_op), .id_funct(id_funct),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_operation(alu_operation), .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg)
  );

  typedef struct {
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic        src, dst;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbres;
    logic [31:0] ea, eb;
    logic [2:0]  eop;
    logic [4:0]  ewr;
  } vec_t;

  vec_t tbl[10];

  // Behavioural picture of the instruction sitting in EX
  typedef struct packed {
    logic        valid, rw, mr, mw, m2r, src;
    logic [4:0]  rs, rt, wreg;
    logic [31:0] rs_val, rt_val, imm_ext;
    logic [2:0]  op;
  } ex_model_t;

  ex_model_t m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; stall = 0; flush = 0; id_valid = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_alu_src = 0; id_reg_dst = 0; id_mem_read = 0; id_mem_write = 0;
    id_reg_write = 0; id_mem_to_reg = 0; id_alu_op = 0; id_funct = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic apply_row(input int i);
    id_valid = 1; id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    id_rs_data = tbl[i].rs_data; id_rt_data = tbl[i].rt_data; id_imm = tbl[i].imm;
    id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_rd = tbl[i].rd;
    id_alu_src = tbl[i].src; id_reg_dst = tbl[i].dst;
    id_alu_op = tbl[i].aluop; id_funct = tbl[i].funct;
    wb_reg_write = tbl[i].wbw; wb_rd = tbl[i].wbrd; wb_result = tbl[i].wbres;
    tick();
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    #1;
  endtask

  function automatic logic [2:0] ref_op(input logic [1:0] aluop, input logic [5:0] funct);
    if (aluop == 2'd0) return 3'd2;
    if (aluop == 2'd1) return 3'd6;
    if (aluop == 2'd3) return 3'd7;
    case (funct)
      6'd32:   return 3'd2;
      6'd34:   return 3'd6;
      6'd36:   return 3'd0;
      6'd37:   return 3'd1;
      6'd42:   return 3'd7;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] v);
    if (mem_reg_write && mem_rd != 0 && mem_rd == idx) return mem_result;
    if (wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_result;
    return v;
  endfunction

  function automatic logic ref_haz();
    return m.valid && m.mr && m.wreg != 0 && id_valid && (id_rs == m.wreg || id_rt == m.wreg);
  endfunction

  task automatic model_step();
    logic haz;
    haz = ref_haz();
    if (rst) m = '0;
    else if (flush || (!stall && haz)) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0;
    end else if (!stall) begin
      m.valid = id_valid; m.rw = id_reg_write; m.mr = id_mem_read;
      m.mw = id_mem_write; m.m2r = id_mem_to_reg; m.src = id_alu_src;
      m.rs = id_rs; m.rt = id_rt;
      m.rs_val = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs) ? wb_result : id_rs_data;
      m.rt_val = (wb_reg_write && wb_rd != 0 && wb_rd == id_rt) ? wb_result : id_rt_data;
      m.imm_ext = 32'($signed(id_imm));
      m.wreg = id_reg_dst ? id_rd : id_rt;
      m.op = ref_op(id_alu_op, id_funct);
    end
  endtask

  initial begin
    //           rs_d    rt_d    imm       rs rt rd src dst op     funct      wbw wbrd wbres  ea      eb            eop     ewr
    tbl[0] = '{32'd5,   32'd7,  16'h0000, 1, 2, 3, 0, 1, 2'b10, 6'b100000, 0, 0, 32'd0,  32'd5,   32'd7,        3'b010, 5'd3};
    tbl[1] = '{32'd10,  32'd0,  16'hFFFE, 1, 9, 0, 1, 0, 2'b00, 6'b000000, 0, 0, 32'd0,  32'd10,  32'hFFFFFFFE, 3'b010, 5'd9};
    tbl[2] = '{32'd3,   32'd4,  16'h0000, 1, 2, 6, 0, 1, 2'b10, 6'b101010, 0, 0, 32'd0,  32'd3,   32'd4,        3'b111, 5'd6};
    tbl[3] = '{32'd8,   32'd8,  16'h0010, 1, 2, 0, 0, 0, 2'b01, 6'b111111, 0, 0, 32'd0,  32'd8,   32'd8,        3'b110, 5'd2};
    tbl[4] = '{32'hF0,  32'h3C, 16'h0000, 1, 2, 4, 0, 1, 2'b10, 6'b100100, 0, 0, 32'd0,  32'hF0,  32'h3C,       3'b000, 5'd4};
    tbl[5] = '{32'hF0,  32'h3C, 16'h0000, 1, 2, 5, 0, 1, 2'b10, 6'b100101, 0, 0, 32'd0,  32'hF0,  32'h3C,       3'b001, 5'd5};
    tbl[6] = '{32'd1,   32'd2,  16'h0000, 1, 2, 7, 0, 1, 2'b10, 6'b000000, 0, 0, 32'd0,  32'd1,   32'd2,        3'b010, 5'd7};
    tbl[7] = '{32'd9,   32'd0,  16'h7FFF, 3, 4, 0, 1, 0, 2'b11, 6'b000000, 0, 0, 32'd0,  32'd9,   32'h00007FFF, 3'b111, 5'd4};
    tbl[8] = '{32'd1,   32'd2,  16'h0000, 6, 7, 8, 0, 1, 2'b10, 6'b100000, 1, 7, 32'd99, 32'd1,   32'd99,       3'b010, 5'd8};
    tbl[9] = '{32'd12,  32'd13, 16'h0000, 0, 0, 9, 0, 1, 2'b10, 6'b100010, 1, 0, 32'd55, 32'd12,  32'd13,       3'b110, 5'd9};

    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("reset_valid", ex_valid, 0);
    check("reset_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    check("reset_op", alu_operation, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_hazard", hazard_stall, 0);

    for (int i = 0; i < 10; i++) begin
      apply_row(i);
      check($sformatf("row%0d_valid", i), ex_valid, 1);
      check($sformatf("row%0d_alu_a", i), alu_a, tbl[i].ea);
      check($sformatf("row%0d_alu_b", i), alu_b, tbl[i].eb);
      check($sformatf("row%0d_op", i), alu_operation, tbl[i].eop);
      check($sformatf("row%0d_wreg", i), ex_write_reg, tbl[i].ewr);
    end

    // forwarding priority on rs, then rt
    clear_inputs();
    id_valid = 1; id_rs = 4; id_rs_data = 1; id_rt = 5; id_rt_data = 2; id_alu_op = 2'b00;
    tick();
    mem_reg_write = 1; mem_rd = 4; mem_result = 11;
    wb_reg_write = 1; wb_rd = 4; wb_result = 22;
    #1 check("fwd_mem_wins", alu_a, 11);
    mem_reg_write = 0;
    #1 check("fwd_wb", alu_a, 22);
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0;
    #1 check("fwd_r0_none", alu_a, 1);
    mem_rd = 5; mem_result = 33;
    #1 check("fwd_rt_store", ex_store_data, 33);
    check("fwd_rt_alu_b", alu_b, 33);

    // load-use hazard and re-capture with WB forward
    clear_inputs();
    id_valid = 1; id_rs = 1; id_rs_data = 100; id_rt = 8; id_imm = 4; id_alu_src = 1;
    id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    tick();
    id_rs = 8; id_rs_data = 0; id_rt = 2; id_rt_data = 3; id_rd = 9; id_reg_dst = 1;
    id_alu_src = 0; id_mem_read = 0; id_mem_to_reg = 0; id_alu_op = 2'b10; id_funct = 6'b100000;
    #1 check("lu_hazard", hazard_stall, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rw", ex_reg_write, 0);
    check("lu_hazard_clear", hazard_stall, 0);
    wb_reg_write = 1; wb_rd = 8; wb_result = 77;
    tick();
    wb_reg_write = 0;
    #1 check("lu_recap_valid", ex_valid, 1);
    check("lu_recap_alu_a", alu_a, 77);
    check("lu_recap_wreg", ex_write_reg, 9);

    // a load targeting r0 never stalls
    clear_inputs();
    id_valid = 1; id_rt = 0; id_mem_read = 1; id_reg_write = 1;
    tick();
    id_mem_read = 0; id_rs = 0; id_rt = 3;
    #1 check("r0_no_hazard", hazard_stall, 0);

    // stall holds for three cycles, then stall with flush bubbles
    clear_inputs();
    apply_row(0);
    stall = 1; id_rs_data = 999; id_rt_data = 888; id_funct = 6'b100010; id_rd = 12;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_valid", ex_valid, 1);
      check("stall_alu_a", alu_a, 5);
      check("stall_alu_b", alu_b, 7);
      check("stall_op", alu_operation, 3'b010);
      check("stall_wreg", ex_write_reg, 3);
    end
    flush = 1;
    tick();
    check("stall_flush_valid", ex_valid, 0);
    check("stall_flush_rw", ex_reg_write, 0);

    // flush alone
    clear_inputs();
    apply_row(2);
    flush = 1;
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_rw", ex_reg_write, 0);

    // reset during a stall with valid content
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_mem_write = 1; id_mem_to_reg = 1; id_reg_write = 1;
    id_alu_op = 2'b01; id_rs = 3; id_rs_data = 5; id_rt = 4;
    tick();
    check("pre_rst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 4'b1111);
    id_valid = 0; stall = 1; rst = 1;
    tick();
    rst = 0; stall = 0;
    #1 check("rst_stall_valid", ex_valid, 0);
    check("rst_stall_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    check("rst_stall_op", alu_operation, 0);

    // randomized run against the reference model
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    m = '0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
      id_alu_op = 2'($urandom);
      id_funct = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'h20 + 6'($urandom_range(0, 10));
      mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
      #1;
      check("rnd_hazard", hazard_stall, ref_haz());
      check("rnd_valid", ex_valid, m.valid);
      check("rnd_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, {m.rw, m.mr, m.mw, m.m2r});
      if (m.valid) begin
        check("rnd_alu_a", alu_a, ref_fwd(m.rs, m.rs_val));
        check("rnd_alu_b", alu_b, m.src ? m.imm_ext : ref_fwd(m.rt, m.rt_val));
        check("rnd_store", ex_store_data, ref_fwd(m.rt, m.rt_val));
        check("rnd_op", alu_operation, m.op);
        check("rnd_wreg", ex_write_reg, m.wreg);
      end
      model_step();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
